// File: rtl/cordic_pkg.sv
// Constants and helpers shared by the pipelined CORDIC rotator and every client
// that schedules work into it.
package cordic_pkg;

  localparam int CORDIC_WIDTH    = 16;
  localparam int ANGLE_PI_2      = 2 ** (CORDIC_WIDTH - 2);
  localparam int ANGLE_PI_4      = 2 ** (CORDIC_WIDTH - 3);
  localparam int CORDIC_GAIN_Q15 = 53961;
  localparam int X_INIT_DEFAULT  = 18000;

  function automatic int cordic_lat(input int width);
    return width + 1;
  endfunction

  // atan(2^-i) on a 2^32 = full-circle scale, rounded to a `width`-bit circle.
  function automatic logic [31:0] cordic_atan(input int i, input int width);
    logic [31:0] full;
    case (i)
      0:       full = 32'h2000_0000;
      1:       full = 32'h12E4_051E;
      2:       full = 32'h09FB_385B;
      3:       full = 32'h0511_11D4;
      4:       full = 32'h028B_0D43;
      5:       full = 32'h0145_D7E1;
      6:       full = 32'h00A2_F61E;
      7:       full = 32'h0051_7C55;
      8:       full = 32'h0028_BE53;
      9:       full = 32'h0014_5F2F;
      10:      full = 32'h000A_2F98;
      11:      full = 32'h0005_17CC;
      12:      full = 32'h0002_8BE6;
      13:      full = 32'h0001_45F3;
      14:      full = 32'h0000_A2FA;
      15:      full = 32'h0000_517D;
      16:      full = 32'h0000_28BE;
      17:      full = 32'h0000_145F;
      18:      full = 32'h0000_0A30;
      19:      full = 32'h0000_0518;
      default: full = 32'h0000_0000;
    endcase
    return (full + (32'd1 << (31 - width))) >> (32 - width);
  endfunction

endpackage

// File: rtl/cordic_sched_if.sv
// Request/response bundle between NCO clients and the CORDIC scheduler.
interface cordic_sched_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WIDTH-1:0]  req_angle;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic signed [WIDTH-1:0] rsp_sin;
  logic signed [WIDTH-1:0] rsp_cos;

  modport master (
    output req_valid, req_angle,
    input  req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos
  );

  modport slave (
    input  req_valid, req_angle,
    output req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos
  );
endinterface

// File: rtl/cordic_12b.sv
// Fully pipelined CORDIC rotator: quadrant-fold input register, WIDTH-1
// rotation stages, output register; latency WIDTH+1 cycles.
module cordic_12b
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic signed [WIDTH-1:0] x_start,
  input  logic signed [WIDTH-1:0] y_start,
  input  logic        [WIDTH-1:0] angle,
  output logic signed [WIDTH-1:0] COSout,
  output logic signed [WIDTH-1:0] SINout
);
  localparam int NST = WIDTH - 1;
  localparam int XW  = WIDTH + 3;  // one growth bit plus two guard fraction bits
  localparam int ZW  = WIDTH + 2;  // two extra fraction bits of residual angle

  function automatic logic [NST-1:0][ZW-1:0] atan_table();
    logic [NST-1:0][ZW-1:0] t;
    for (int i = 0; i < NST; i++) t[i] = ZW'(cordic_atan(i, ZW));
    return t;
  endfunction

  localparam logic [NST-1:0][ZW-1:0] ATAN = atan_table();

  logic signed [XW-1:0] x [NST+1];
  logic signed [XW-1:0] y [NST+1];
  logic        [ZW-1:0] z [NST+1];
  logic signed [XW-1:0] xs, ys;

  assign xs = {x_start[WIDTH-1], x_start, 2'b00};
  assign ys = {y_start[WIDTH-1], y_start, 2'b00};

  // NOTE: the datapath registers are reset rather than left as plain storage, so
  // a reset flushes every in-flight operation and the outputs read 0 afterwards.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x[0] <= '0;
      y[0] <= '0;
      z[0] <= '0;
    end else begin
      case (angle[WIDTH-1 -: 2])
        2'b01: begin  // second quadrant: pre-rotate by +pi/2
          x[0] <= -ys;
          y[0] <= xs;
          z[0] <= {2'b00, angle[WIDTH-3:0], 2'b00};
        end
        2'b10: begin  // third quadrant: pre-rotate by -pi/2
          x[0] <= ys;
          y[0] <= -xs;
          z[0] <= {2'b11, angle[WIDTH-3:0], 2'b00};
        end
        default: begin
          x[0] <= xs;
          y[0] <= ys;
          z[0] <= {angle, 2'b00};
        end
      endcase
    end
  end

  for (genvar i = 0; i < NST; i++) begin : g_stage
    always_ff @(posedge clk) begin
      if (!resetn) begin
        x[i+1] <= '0;
        y[i+1] <= '0;
        z[i+1] <= '0;
      end else if (z[i][ZW-1]) begin
        x[i+1] <= x[i] + (y[i] >>> i);
        y[i+1] <= y[i] - (x[i] >>> i);
        z[i+1] <= z[i] + ATAN[i];
      end else begin
        x[i+1] <= x[i] - (y[i] >>> i);
        y[i+1] <= y[i] + (x[i] >>> i);
        z[i+1] <= z[i] - ATAN[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      COSout <= '0;
      SINout <= '0;
    end else begin
      COSout <= x[NST][WIDTH+1:2];
      SINout <= y[NST][WIDTH+1:2];
    end
  end

endmodule

// File: rtl/cordic_sched_rr_arbiter.sv
// Pointer-based round-robin arbiter: combinational one-hot grant searched from
// ptr upward, pointer moves past each winner.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id
);
  logic [IDW-1:0] ptr;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // NOTE: every output of this block gets a default before the search loop, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    sum       = '0;
    idx       = '0;
    if (en && resetn) begin
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, ptr} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        idx = sum[IDW-1:0];
        if (!gnt_valid && req[idx]) begin
          gnt_valid  = 1'b1;
          gnt_id     = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!resetn)        ptr <= '0;
    else if (gnt_valid) ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end

endmodule

// File: rtl/cordic_sched.sv
// Shares one pipelined CORDIC rotator among NREQ requesters; a tag pipeline
// matched to the core latency returns each result with its requester id.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int NREQ   = 4,
  parameter  int X_INIT = X_INIT_DEFAULT,
  localparam int IDW    = $clog2(NREQ),
  localparam int LAT    = cordic_lat(WIDTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  output logic          busy,
  cordic_sched_if.slave bus
);
  logic [NREQ-1:0]            grant;
  logic                       gnt_valid;
  logic [IDW-1:0]             gnt_id;
  logic [NREQ-1:0][WIDTH-1:0] angles;
  logic [WIDTH-1:0]           core_angle;
  logic signed [WIDTH-1:0]    core_sin, core_cos;
  logic [LAT-1:0]             tag_vld;
  logic [LAT-1:0][IDW-1:0]    tag_id;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .req       (bus.req_valid),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign bus.req_ready = grant;
  assign angles        = bus.req_angle;
  assign core_angle    = gnt_valid ? angles[gnt_id] : '0;

  cordic_12b #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .resetn  (resetn),
    .x_start (WIDTH'(X_INIT)),
    .y_start ('0),
    .angle   (core_angle),
    .COSout  (core_cos),
    .SINout  (core_sin)
  );

  // Tags travel alongside the core so each result leaves with its requester id.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[LAT-2:0], gnt_valid};
      tag_id  <= {tag_id[LAT-2:0], gnt_id};
    end
  end

  assign bus.rsp_valid = tag_vld[LAT-1];
  assign bus.rsp_id    = tag_id[LAT-1];
  assign bus.rsp_sin   = core_sin;
  assign bus.rsp_cos   = core_cos;
  assign busy          = |tag_vld;

endmodule
